// File: rtl/regfile_port_sequencer.sv
// Register-file port sequencer for the multi-cycle datapath. It runs a three-state operand-fetch FSM
// with write-bypass capture, and alongside it a registered single-pulse write-back path.
module regfile_port_sequencer #(
  parameter int DATA_W            = 32,
  parameter int ADDR_W            = 5,
  parameter bit ZERO_REG_WRITABLE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_rs,
  input  logic [ADDR_W-1:0] rd_rt,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] rf_r_addr_1,
  output logic [ADDR_W-1:0] rf_r_addr_2,
  input  logic [DATA_W-1:0] rf_data_1,
  input  logic [DATA_W-1:0] rf_data_2,
  output logic [ADDR_W-1:0] rf_w_addr,
  output logic [DATA_W-1:0] rf_data_in,
  output logic              rf_we,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // A producer holds valid and its payload steady until that edge. The sequencer never
  // withdraws op_valid before op_ready is seen.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] rs_q;
  logic [ADDR_W-1:0] rt_q;
  logic [DATA_W-1:0] cap_a;
  logic [DATA_W-1:0] cap_b;
  logic              wb_kept;

  assign rd_ready    = (state == IDLE);
  assign busy        = (state != IDLE);
  assign dbg_state   = state;
  assign wb_ready    = rst_n;
  assign rf_r_addr_1 = rs_q;
  assign rf_r_addr_2 = rt_q;

  // The zero rule outranks the bypass, and the bypass outranks the regfile read.
  always_comb begin
    cap_a = rf_data_1;
    cap_b = rf_data_2;
    if (rf_we && (rf_w_addr == rs_q)) cap_a = rf_data_in;
    if (rf_we && (rf_w_addr == rt_q)) cap_b = rf_data_in;
    if (!ZERO_REG_WRITABLE && (rs_q == '0)) cap_a = '0;
    if (!ZERO_REG_WRITABLE && (rt_q == '0)) cap_b = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rs_q     <= '0;
      rt_q     <= '0;
      op_valid <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_valid) begin
            rs_q  <= rd_rs;
            rt_q  <= rd_rt;
            state <= FETCH;
          end
        end
        FETCH: begin
          op_a     <= cap_a;
          op_b     <= cap_b;
          op_valid <= 1'b1;
          state    <= HOLD;
        end
        HOLD: begin
          if (op_ready) begin
            op_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A write to $zero is still accepted, but it never turns into a regfile write pulse.
  assign wb_kept = wb_valid && (ZERO_REG_WRITABLE || (wb_addr != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we      <= 1'b0;
      rf_w_addr  <= '0;
      rf_data_in <= '0;
    end else begin
      rf_we <= wb_kept;
      if (wb_valid) begin
        rf_w_addr  <= wb_addr;
        rf_data_in <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Directed bench for regfile_port_sequencer. It uses a behavioural regfile in which register i
// starts out holding i.
module tb_regfile_port_sequencer;

  logic        clk;
  logic        rst_n;
  logic        rd_valid;
  logic        rd_ready;
  logic [4:0]  rd_rs;
  logic [4:0]  rd_rt;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [4:0]  rf_r_addr_1;
  logic [4:0]  rf_r_addr_2;
  logic [31:0] rf_data_1;
  logic [31:0] rf_data_2;
  logic [4:0]  rf_w_addr;
  logic [31:0] rf_data_in;
  logic        rf_we;
  logic        busy;
  logic [1:0]  dbg_state;

  logic [31:0] regs [32];
  logic        model_loaded;
  int          tests;
  int          fails;

  regfile_port_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_rs       (rd_rs),
    .rd_rt       (rd_rt),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .rf_r_addr_1 (rf_r_addr_1),
    .rf_r_addr_2 (rf_r_addr_2),
    .rf_data_1   (rf_data_1),
    .rf_data_2   (rf_data_2),
    .rf_w_addr   (rf_w_addr),
    .rf_data_in  (rf_data_in),
    .rf_we       (rf_we),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The regfile model reads combinationally and commits writes on the rising edge.
  assign rf_data_1 = regs[rf_r_addr_1];
  assign rf_data_2 = regs[rf_r_addr_2];

  always @(posedge clk) begin
    if (!model_loaded) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'(i);
    end else if (rf_we) begin
      regs[rf_w_addr] <= rf_data_in;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; rd_valid = 1'b0; rd_rs = '0; rd_rt = '0; op_ready = 1'b0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0; model_loaded = 1'b0;

    // Reset: hold it low, then release it.
    repeat (2) @(posedge clk);
    model_loaded = 1'b1;
    #2;
    chk("rst_op_valid", 32'(op_valid), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_wb_ready", 32'(wb_ready), 32'd0);
    chk("rst_op_a", op_a, 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("out_op_valid", 32'(op_valid), 32'd0);
    chk("out_rf_we", 32'(rf_we), 32'd0);
    chk("out_busy", 32'(busy), 32'd0);
    chk("out_rd_ready", 32'(rd_ready), 32'd1);
    chk("out_wb_ready", 32'(wb_ready), 32'd1);

    // Basic fetch: rs=3, rt=7.
    rd_valid = 1'b1; rd_rs = 5'd3; rd_rt = 5'd7; op_ready = 1'b1;
    step();
    rd_valid = 1'b0;
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t2_rd_ready", 32'(rd_ready), 32'd0);
    chk("t2_op_valid_fetch", 32'(op_valid), 32'd0);
    chk("t2_raddr1", 32'(rf_r_addr_1), 32'd3);
    chk("t2_raddr2", 32'(rf_r_addr_2), 32'd7);
    step();
    chk("t2_op_valid", 32'(op_valid), 32'd1);
    chk("t2_op_a", op_a, 32'd3);
    chk("t2_op_b", op_b, 32'd7);
    step();
    chk("t2_op_valid_fall", 32'(op_valid), 32'd0);
    chk("t2_rd_ready_back", 32'(rd_ready), 32'd1);

    // A write-back in the same cycle as the fetch handshake is bypassed.
    op_ready = 1'b0;
    rd_valid = 1'b1; rd_rs = 5'd3; rd_rt = 5'd3;
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEADBEEF;
    step();
    rd_valid = 1'b0; wb_valid = 1'b0;
    chk("t3_rf_we", 32'(rf_we), 32'd1);
    chk("t3_w_addr", 32'(rf_w_addr), 32'd3);
    chk("t3_w_data", rf_data_in, 32'hDEADBEEF);
    step();
    chk("t3_op_a", op_a, 32'hDEADBEEF);
    chk("t3_op_b", op_b, 32'hDEADBEEF);
    chk("t3_we_single", 32'(rf_we), 32'd0);
    op_ready = 1'b1;
    step();
    chk("t3_op_valid_fall", 32'(op_valid), 32'd0);
    rd_valid = 1'b1; rd_rs = 5'd3; rd_rt = 5'd1;
    step();
    rd_valid = 1'b0;
    step();
    chk("t3_refetch_a", op_a, 32'hDEADBEEF);
    chk("t3_refetch_b", op_b, 32'd1);
    step();

    // A write to $zero is accepted but never produces a write pulse.
    op_ready = 1'b0;
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234;
    step();
    wb_valid = 1'b0;
    chk("t4_we_1", 32'(rf_we), 32'd0);
    rd_valid = 1'b1; rd_rs = 5'd0; rd_rt = 5'd2;
    step();
    rd_valid = 1'b0;
    chk("t4_we_2", 32'(rf_we), 32'd0);
    step();
    chk("t4_op_a_zero", op_a, 32'd0);
    chk("t4_op_b", op_b, 32'd2);
    op_ready = 1'b1;
    step();

    // While in HOLD, the operands stay put even if the source register is written.
    op_ready = 1'b0;
    rd_valid = 1'b1; rd_rs = 5'd4; rd_rt = 5'd4;
    step();
    rd_valid = 1'b0;
    step();
    chk("t5_op_a_init", op_a, 32'd4);
    wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h55;
    rd_valid = 1'b1; rd_rs = 5'd9; rd_rt = 5'd9;
    for (int i = 0; i < 5; i++) begin
      step();
      wb_valid = 1'b0;
      chk("t5_op_valid", 32'(op_valid), 32'd1);
      chk("t5_op_a", op_a, 32'd4);
      chk("t5_op_b", op_b, 32'd4);
      chk("t5_rd_ready", 32'(rd_ready), 32'd0);
      chk("t5_raddr1", 32'(rf_r_addr_1), 32'd4);
    end
    rd_valid = 1'b0; op_ready = 1'b1;
    step();
    chk("t5_rd_ready_back", 32'(rd_ready), 32'd1);
    chk("t5_op_valid_fall", 32'(op_valid), 32'd0);
    rd_valid = 1'b1; rd_rs = 5'd4; rd_rt = 5'd0;
    step();
    rd_valid = 1'b0;
    step();
    chk("t5_refetch_a", op_a, 32'h55);
    chk("t5_refetch_b", op_b, 32'd0);
    step();

    // A reset during FETCH drops both the operand and the pending write pulse.
    op_ready = 1'b0;
    rd_valid = 1'b1; rd_rs = 5'd6; rd_rt = 5'd6;
    wb_valid = 1'b1; wb_addr = 5'd6; wb_data = 32'h66;
    step();
    rd_valid = 1'b0; wb_valid = 1'b0;
    chk("t6_pre_we", 32'(rf_we), 32'd1);
    chk("t6_pre_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_op_valid", 32'(op_valid), 32'd0);
    chk("t6_rf_we", 32'(rf_we), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_state", 32'(dbg_state), 32'd0);
    chk("t6_wb_ready", 32'(wb_ready), 32'd0);
    step();
    rst_n = 1'b1;
    #1;
    rd_valid = 1'b1; rd_rs = 5'd5; rd_rt = 5'd6; op_ready = 1'b1;
    step();
    rd_valid = 1'b0;
    step();
    chk("t6_op_a", op_a, 32'd5);
    chk("t6_op_b_no_write", op_b, 32'd6);
    step();
    chk("t6_op_valid_fall", 32'(op_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
